// File: rtl/countdown_arbiter.sv
// Round-robin owner of a shared down-counter timer: grants one requester,
// loads its interval, counts down on tick and pulses done on expiry.
module countdown_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*WIDTH-1:0]   len_i,
  input  logic                    tick_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [NREQ-1:0]         done_o,
  output logic                    busy_o,
  output logic [WIDTH-1:0]        count_out_o
);

  localparam int unsigned IDXW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   done_q;
  logic              busy_q;
  logic [WIDTH-1:0]  count_q;
  logic [IDXW-1:0]   ptr_q;
  logic [IDXW-1:0]   owner_q;

  logic              sel_valid_d;
  logic [IDXW-1:0]   sel_idx_d;
  int unsigned       cand;
  logic [WIDTH-1:0]  len_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign len_arr[i] = len_i[i*WIDTH +: WIDTH];
  end

  // First requesting index after the pointer, wrapping modulo NREQ.
  always_comb begin
    sel_valid_d = 1'b0;
    sel_idx_d   = '0;
    cand        = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr_q) + k) % NREQ;
      if (!sel_valid_d && req_i[IDXW'(cand)]) begin
        sel_valid_d = 1'b1;
        sel_idx_d   = IDXW'(cand);
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      ptr_q   <= IDXW'(NREQ - 1);
      owner_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (sel_valid_d) begin
            state_q <= COUNT;
            grant_q <= NREQ'(1) << sel_idx_d;
            busy_q  <= 1'b1;
            count_q <= len_arr[sel_idx_d];
            ptr_q   <= sel_idx_d;
            owner_q <= sel_idx_d;
          end else begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
          end
        end
        COUNT: begin
          // An abandoned request releases the timer silently.
          if (!req_i[owner_q]) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            count_q <= '0;
          end else if (count_q == '0) begin
            state_q <= DONE;
            done_q  <= grant_q;
          end else if (tick_i) begin
            count_q <= count_q - WIDTH'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          grant_q <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign count_out_o = count_q;

endmodule

// File: tb/tb_countdown_arbiter.sv
// Directed bench for countdown_arbiter with an owner/remaining-count model
// checked every cycle, plus hand-computed spot values.
module tb_countdown_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 4;

  logic              clk  = 1'b0;
  logic              rst  = 1'b1;
  logic              tick = 1'b0;
  logic [NREQ-1:0]   req  = '0;
  logic [NREQ*W-1:0] len  = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [W-1:0]      cnt;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  int cyc    = 0;

  // Model: who owns the timer (-1 = nobody), what is left, and whether
  // this is the expiry cycle.
  int m_owner = -1;
  int m_cnt   = 0;
  bit m_fin   = 1'b0;
  int m_ptr   = NREQ - 1;

  countdown_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .req_i       (req),
    .len_i       (len),
    .tick_i      (tick),
    .grant_o     (grant),
    .done_o      (done),
    .busy_o      (busy),
    .count_out_o (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    bit found;
    int c;
    cyc++;
    found = 1'b0;
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_fin = 1'b0; m_ptr = NREQ - 1;
    end else if (m_fin) begin
      m_owner = -1; m_cnt = 0; m_fin = 1'b0;
    end else if (m_owner < 0) begin
      m_cnt = 0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (!found && req[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_ptr   = c;
          m_cnt   = int'(len[c*W +: W]);
        end
      end
    end else if (!req[m_owner]) begin
      m_owner = -1; m_cnt = 0;
    end else if (m_cnt == 0) begin
      m_fin = 1'b1;
    end else if (tick) begin
      m_cnt = m_cnt - 1;
    end
  end

  always @(negedge clk) begin
    int eg;
    if (cmp_en) begin
      eg = (m_owner >= 0) ? (1 << m_owner) : 0;
      chk("model_grant", int'(grant), eg);
      chk("model_done",  int'(done),  m_fin ? eg : 0);
      chk("model_busy",  int'(busy),  (m_owner >= 0) ? 1 : 0);
      chk("model_count", int'(cnt),   m_cnt);
    end
  end

  initial begin
    step(2);
    cmp_en = 1'b1;
    chk("reset_grant", int'(grant), 0);
    chk("reset_done",  int'(done),  0);
    chk("reset_busy",  int'(busy),  0);
    chk("reset_count", int'(cnt),   0);
    rst = 1'b0;

    // Single request, len 3
    req = 4'b0001; len[0 +: W] = 4'd3; tick = 1'b1;
    step(1);
    chk("single_grant_e0", int'(grant), 1);
    chk("single_count_e0", int'(cnt), 3);
    chk("single_busy_e0",  int'(busy), 1);
    step(1); chk("single_count_e1", int'(cnt), 2);
    step(1); chk("single_count_e2", int'(cnt), 1);
    step(1); chk("single_count_e3", int'(cnt), 0);
    chk("single_nodone_e3", int'(done), 0);
    step(1);
    chk("single_done_e4",  int'(done), 1);
    chk("single_grant_e4", int'(grant), 1);
    req = '0;
    step(1);
    chk("single_grant_e5", int'(grant), 0);
    chk("single_done_e5",  int'(done), 0);

    // Fairness: requester 0 keeps asking, others drop after done
    do_reset();
    len = {4'd1, 4'd1, 4'd1, 4'd1};
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step(1); chk("fair_grant_a", int'(grant), 1 << i);
      step(1); chk("fair_grant_b", int'(grant), 1 << i);
      step(1); chk("fair_done",    int'(done),  1 << i);
      chk("fair_grant_c", int'(grant), 1 << i);
      if (i != 0) req[i] = 1'b0;
      step(1); chk("fair_idle", int'(grant), 0);
    end
    step(1); chk("fair_fifth_grant", int'(grant), 1);
    req = '0;
    step(2);

    // Tick gating, len 2 on requester 2
    req = 4'b0100; len[8 +: W] = 4'd2; tick = 1'b0;
    step(1); chk("tick_count_e0", int'(cnt), 2);
    chk("tick_grant_e0", int'(grant), 4);
    tick = 1'b1; step(1); chk("tick_count_e1", int'(cnt), 1);
    tick = 1'b0; step(1); chk("tick_hold_e2", int'(cnt), 1);
    tick = 1'b1; step(1); chk("tick_count_e3", int'(cnt), 0);
    chk("tick_nodone_e3", int'(done), 0);
    tick = 1'b0; step(1); chk("tick_done_e4", int'(done), 4);
    req = '0; tick = 1'b1;
    step(1); chk("tick_idle_e5", int'(grant), 0);

    // Zero length on requester 1
    req = 4'b0010; len[4 +: W] = 4'd0;
    step(1);
    chk("zero_grant_e0", int'(grant), 2);
    chk("zero_count_e0", int'(cnt), 0);
    chk("zero_nodone_e0", int'(done), 0);
    step(1); chk("zero_done_e1", int'(done), 2);
    req = '0;
    step(1);
    chk("zero_grant_e2", int'(grant), 0);
    chk("zero_busy_e2",  int'(busy), 0);

    // Abort of requester 1 while requester 3 waits
    do_reset();
    req = 4'b1010; len[4 +: W] = 4'd5; len[12 +: W] = 4'd4;
    step(1);
    chk("abort_grant_e0", int'(grant), 2);
    chk("abort_count_e0", int'(cnt), 5);
    step(2); chk("abort_count_e2", int'(cnt), 3);
    req[1] = 1'b0;
    step(1);
    chk("abort_grant_e3", int'(grant), 0);
    chk("abort_done_e3",  int'(done), 0);
    chk("abort_busy_e3",  int'(busy), 0);
    step(1);
    chk("abort_next_grant", int'(grant), 8);
    chk("abort_next_count", int'(cnt), 4);
    step(5); chk("abort_next_done", int'(done), 8);
    req = '0;
    step(1);

    // Reset while requester 3 is mid-count
    req = 4'b1000;
    step(1); chk("rst_grant_e0", int'(grant), 8);
    step(2); chk("rst_count_e2", int'(cnt), 2);
    rst = 1'b1;
    step(1);
    chk("rst_grant", int'(grant), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_count", int'(cnt), 0);
    rst = 1'b0;
    req = 4'b1111; len = {4'd1, 4'd1, 4'd1, 4'd1};
    step(1); chk("rst_next_grant", int'(grant), 1);
    req = '0;
    step(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
